aes_sbox_pipe: RTL and testbench

Parametrised, pipelined AES S-box unit processing LANES bytes per beat, selectable per beat between forward (SubBytes) and inverse (InvSubBytes) substitution.
Uses a valid/ready handshake, carries an opaque tag alongside each beat, and supports a synchronous flush.
Serves the cipher round datapath (LANES=16) and the key-expansion SubWord path (LANES=4).

---
 rtl/aes_pkg.sv | 61 ++++++
 rtl/aes_sbox_pipe_if.sv | 29 ++
 rtl/aes_sbox_lane.sv | 23 ++
 rtl/aes_sbox_pipe.sv | 164 ++++++++++++++++
 tb/tb_aes_sbox_pipe.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES byte types and GF(2^8) helpers used by the S-box datapath.
// Contents: sbox_mode_e (forward/inverse select), aes_byte_t, lane limit,
// and the field arithmetic (xtime, multiply, inverse, affine maps).
package aes_pkg;

  typedef enum logic {SBOX_FWD = 1'b0, SBOX_INV = 1'b1} sbox_mode_e;

  typedef logic [7:0] aes_byte_t;

  localparam int unsigned AES_SBOX_MAX_LANES = 16;

  // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic aes_byte_t xtime(input aes_byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add GF(2^8) multiply; consumes b from its LSB.
  function automatic aes_byte_t gf_mul(input aes_byte_t a, input aes_byte_t b);
    aes_byte_t p;
    aes_byte_t aa;
    aes_byte_t bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      bb = {1'b0, bb[7:1]};
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as AES requires).
  function automatic aes_byte_t gf_inv(input aes_byte_t x);
    aes_byte_t x3;
    aes_byte_t x7;
    aes_byte_t x15;
    aes_byte_t x31;
    aes_byte_t x63;
    aes_byte_t x127;
    x3   = gf_mul(gf_mul(x, x), x);
    x7   = gf_mul(gf_mul(x3, x3), x);
    x15  = gf_mul(gf_mul(x7, x7), x);
    x31  = gf_mul(gf_mul(x15, x15), x);
    x63  = gf_mul(gf_mul(x31, x31), x);
    x127 = gf_mul(gf_mul(x63, x63), x);
    return gf_mul(x127, x127);
  endfunction

  // Forward affine map: x ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  function automatic aes_byte_t affine_fwd(input aes_byte_t x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
             ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  // Inverse affine map: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
  function automatic aes_byte_t affine_inv(input aes_byte_t x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  endfunction

endpackage

// File: rtl/aes_sbox_pipe_if.sv
// Handshake bus of the pipelined S-box unit.
// master: upstream/downstream agent (drives in_*, out_ready).
// slave : the S-box pipe (drives in_ready, out_valid, out_data, out_tag).
interface aes_sbox_pipe_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned TAG_W = 4
);
  localparam int unsigned DATA_W = 8 * LANES;

  logic              in_valid;
  logic              in_ready;
  logic              in_inv;
  logic [DATA_W-1:0] in_data;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, in_inv, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_inv, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/aes_sbox_lane.sv
// Combinational single-byte AES S-box, forward or inverse by mode.
// One GF(2^8) inversion core is shared; the affine maps sit on its input
// (inverse direction) or output (forward direction).
// Ports: mode (SBOX_FWD/SBOX_INV), din (byte in), dout_c (substituted byte).
module aes_sbox_lane
  import aes_pkg::*;
(
  input  sbox_mode_e mode,
  input  aes_byte_t  din,
  output aes_byte_t  dout_c
);

  aes_byte_t core_in;
  aes_byte_t core_out;

  // Inverse: undo affine, then invert. Forward: invert, then affine.
  always_comb begin
    core_in  = (mode == SBOX_INV) ? affine_inv(din) : din;
    core_out = gf_inv(core_in);
    dout_c   = (mode == SBOX_INV) ? core_out : affine_fwd(core_out);
  end

endmodule

// File: rtl/aes_sbox_pipe.sv
// Pipelined AES S-box unit: LANES bytes per beat, per-beat forward/inverse
// select, valid/ready handshake with an opaque tag and synchronous flush.
// Ports: clk, rst_n (async, active-low), flush (clears in-flight beats),
//        bus (aes_sbox_pipe_if.slave: in_valid/in_ready/in_inv/in_data/in_tag,
//        out_valid/out_ready/out_data/out_tag).
// Optional AES_SBOX_PIPE_CHECK_EN: adds err_beat (output lane fails the
// round-trip check) and err_sticky (latched on any erroneous output transfer).
module aes_sbox_pipe
  import aes_pkg::*;
#(
  parameter int unsigned LANES   = 4,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned TAG_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
`ifdef AES_SBOX_PIPE_CHECK_EN
  output logic err_beat,
  output logic err_sticky,
`endif
  aes_sbox_pipe_if.slave bus
);

  sbox_mode_e                         in_mode;
  aes_byte_t [LANES-1:0]              in_bytes;
  aes_byte_t [LANES-1:0]              sub_bytes;
  aes_byte_t [LANES-1:0]              out_bytes;
  logic                               accept_c;
  logic [LATENCY-1:0]                 ready;
  logic [LATENCY-1:0]                 stage_valid;
  aes_byte_t [LATENCY-1:0][LANES-1:0] stage_data;
  logic [LATENCY-1:0][TAG_W-1:0]      stage_tag;
`ifdef AES_SBOX_PIPE_CHECK_EN
  aes_byte_t [LATENCY-1:0][LANES-1:0] stage_orig;
  logic [LATENCY-1:0]                 stage_inv;
  sbox_mode_e                         chk_mode;
  aes_byte_t [LANES-1:0]              recon;
`endif

  assign in_mode  = sbox_mode_e'(bus.in_inv);
  assign in_bytes = bus.in_data;

`ifdef AES_SBOX_PIPE_CHECK_EN
  // Round-trip check runs the output through the opposite direction.
  assign chk_mode = stage_inv[LATENCY-1] ? SBOX_FWD : SBOX_INV;
`endif

  // Per-lane substitution ahead of stage 0 (plus the checker lanes).
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    aes_sbox_lane u_sub (
      .mode   (in_mode),
      .din    (in_bytes[i]),
      .dout_c (sub_bytes[i])
    );
`ifdef AES_SBOX_PIPE_CHECK_EN
    aes_sbox_lane u_chk (
      .mode   (chk_mode),
      .din    (out_bytes[i]),
      .dout_c (recon[i])
    );
`endif
  end

  // Stage k can load when any stage from k to the output is free, or the
  // output is draining: the unrolled form of ready_k = !valid_k || ready_k+1.
  for (genvar k = 0; k < LATENCY; k++) begin : g_ready
    assign ready[k] = ~(&stage_valid[LATENCY-1:k]) | bus.out_ready;
  end

  // Flush blocks acceptance so a beat presented alongside it is not taken.
  assign accept_c     = bus.in_valid && ready[0] && !flush;
  assign bus.in_ready = ready[0] && !flush;

  // Pipeline stages: load from the previous stage (or the input) when ready.
  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    logic                  v_q;
    aes_byte_t [LANES-1:0] d_q;
    logic [TAG_W-1:0]      t_q;
    logic                  v_in;
    aes_byte_t [LANES-1:0] d_in;
    logic [TAG_W-1:0]      t_in;
`ifdef AES_SBOX_PIPE_CHECK_EN
    aes_byte_t [LANES-1:0] o_q;
    logic                  m_q;
    aes_byte_t [LANES-1:0] o_in;
    logic                  m_in;
`endif

    if (k == 0) begin : g_head
      assign v_in = accept_c;
      assign d_in = sub_bytes;
      assign t_in = bus.in_tag;
`ifdef AES_SBOX_PIPE_CHECK_EN
      assign o_in = in_bytes;
      assign m_in = bus.in_inv;
`endif
    end else begin : g_body
      assign v_in = stage_valid[k-1];
      assign d_in = stage_data[k-1];
      assign t_in = stage_tag[k-1];
`ifdef AES_SBOX_PIPE_CHECK_EN
      assign o_in = stage_orig[k-1];
      assign m_in = stage_inv[k-1];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        d_q <= '0;
        t_q <= '0;
      end else begin
        if (flush) begin
          v_q <= 1'b0;
        end else if (ready[k]) begin
          v_q <= v_in;
        end
        if (ready[k]) begin
          d_q <= d_in;
          t_q <= t_in;
        end
      end
    end

`ifdef AES_SBOX_PIPE_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        o_q <= '0;
        m_q <= 1'b0;
      end else if (ready[k]) begin
        o_q <= o_in;
        m_q <= m_in;
      end
    end

    assign stage_orig[k] = o_q;
    assign stage_inv[k]  = m_q;
`endif

    assign stage_valid[k] = v_q;
    assign stage_data[k]  = d_q;
    assign stage_tag[k]   = t_q;
  end

  assign out_bytes     = stage_data[LATENCY-1];
  assign bus.out_valid = stage_valid[LATENCY-1];
  assign bus.out_data  = out_bytes;
  assign bus.out_tag   = stage_tag[LATENCY-1];

`ifdef AES_SBOX_PIPE_CHECK_EN
  assign err_beat = stage_valid[LATENCY-1] && (recon != stage_orig[LATENCY-1]);

  // Sticky error latches only on a beat that actually leaves the unit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
    end else if (err_beat && bus.out_ready) begin
      err_sticky <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// Bench for aes_sbox_pipe (LANES=4, LATENCY=2, TAG_W=4): directed steps plus
// randomized traffic, scored against a table-driven model of the S-box.
module tb_aes_sbox_pipe;

  localparam int unsigned LANES   = 4;
  localparam int unsigned LATENCY = 2;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned DW      = 8 * LANES;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
`ifdef AES_SBOX_PIPE_CHECK_EN
  logic err_beat;
  logic err_sticky;
  logic [DW-1:0] fault_val;
`endif

  always #5 clk = ~clk;

  aes_sbox_pipe_if #(.LANES(LANES), .TAG_W(TAG_W)) bus ();

  aes_sbox_pipe #(.LANES(LANES), .LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
`ifdef AES_SBOX_PIPE_CHECK_EN
    .err_beat   (err_beat),
    .err_sticky (err_sticky),
`endif
    .bus        (bus)
  );

  // Published AES S-box, one row of 16 entries per word (entry 0 leftmost).
  logic [127:0] sbox_rows [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  logic [7:0] fwd_tbl [256];
  logic [7:0] inv_tbl [256];

  typedef struct packed {
    logic [DW-1:0]    data;
    logic [TAG_W-1:0] tag;
  } beat_t;

  beat_t   exp_q [$];
  int      n_cmp = 0;
  int      n_err = 0;
  int      n_in  = 0;
  int      n_out = 0;
  int      mark;
  logic    last_in_ready;
  logic    skip_data = 1'b0;
  logic [DW-1:0] beat_c;

  function automatic logic [DW-1:0] ref_sub(input logic [DW-1:0] d, input logic inv);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(LANES); i++)
      r[8*i +: 8] = inv ? inv_tbl[d[8*i +: 8]] : fwd_tbl[d[8*i +: 8]];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // One clock: settle, score any transfers, then advance to the next negedge.
  task automatic tick();
    beat_t e;
    #1;
    last_in_ready = bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      n_out++;
      chk("out_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (!skip_data) begin
          chk("out_data", 64'(bus.out_data), 64'(e.data));
          chk("out_tag", 64'(bus.out_tag), 64'(e.tag));
`ifdef AES_SBOX_PIPE_CHECK_EN
          chk("err_beat_clean", 64'(err_beat), 64'd0);
`endif
        end
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      n_in++;
      exp_q.push_back(beat_t'{data: ref_sub(bus.in_data, bus.in_inv), tag: bus.in_tag});
    end
    if (flush) exp_q.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) tick();
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic sweep();
    for (int j = 0; j < 256; j++) begin
      bus.in_valid = 1'b1;
      bus.in_inv   = j[0];
      for (int i = 0; i < int'(LANES); i++) bus.in_data[8*i +: 8] = 8'((j + 64 * i) % 256);
      bus.in_tag   = TAG_W'(j);
      tick();
      chk("sweep_in_ready", 64'(last_in_ready), 64'd1);
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) fwd_tbl[i] = sbox_rows[i / 16][8 * (15 - (i % 16)) +: 8];
    for (int i = 0; i < 256; i++) inv_tbl[fwd_tbl[i]] = 8'(i);

    bus.in_valid  = 1'b0;
    bus.in_inv    = 1'b0;
    bus.in_data   = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    // Reset values.
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Forward single beat, latency 2.
    bus.in_valid = 1'b1;
    bus.in_inv   = 1'b0;
    bus.in_data  = 32'hFF530100;
    bus.in_tag   = 4'h5;
    tick();
    bus.in_valid = 1'b0;
    chk("fwd_lat1_valid", 64'(bus.out_valid), 64'd0);
    tick();
    chk("fwd_valid", 64'(bus.out_valid), 64'd1);
    chk("fwd_data", 64'(bus.out_data), 64'h16ED7C63);
    chk("fwd_tag", 64'(bus.out_tag), 64'h5);
    tick();

    // Inverse single beat.
    bus.in_valid = 1'b1;
    bus.in_inv   = 1'b1;
    bus.in_data  = 32'h16ED7C63;
    bus.in_tag   = 4'hA;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("inv_valid", 64'(bus.out_valid), 64'd1);
    chk("inv_data", 64'(bus.out_data), 64'hFF530100);
    chk("inv_tag", 64'(bus.out_tag), 64'hA);
    tick();

    // Full byte sweep, back-to-back: 256 outputs within 256+LATENCY cycles.
    mark = n_out;
    sweep();
    for (int c = 0; c < int'(LATENCY); c++) tick();
    chk("sweep_out_count", 64'(n_out - mark), 64'd256);
    chk("sweep_queue_empty", 64'(exp_q.size()), 64'd0);

    // Back-pressure: only LATENCY beats fit, output held steady.
    bus.out_ready = 1'b0;
    mark = n_in;
    beat_c = $urandom;
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1'b1;
      bus.in_inv   = 1'($urandom);
      bus.in_data  = beat_c;
      bus.in_tag   = TAG_W'($urandom);
      tick();
      if (n_in != mark + c) beat_c = $urandom;
      if (bus.out_valid && exp_q.size() > 0)
        chk("stall_hold_data", 64'(bus.out_data), 64'(exp_q[0].data));
    end
    chk("stall_accepted", 64'(n_in - mark), 64'(LATENCY));
    chk("stall_in_ready", 64'(last_in_ready), 64'd0);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    bus.in_valid = 1'b0;
    drain("stall_drain");

    // Randomized traffic with random back-pressure.
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_inv    = 1'($urandom);
      bus.in_data   = $urandom;
      bus.in_tag    = TAG_W'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain("random_drain");

    // Flush with two beats in flight.
    bus.out_ready = 1'b0;
    mark = n_in;
    for (int c = 0; c < 2; c++) begin
      bus.in_valid = 1'b1;
      bus.in_inv   = 1'b0;
      bus.in_data  = $urandom;
      bus.in_tag   = TAG_W'(c);
      tick();
    end
    chk("flush_preload", 64'(n_in - mark), 64'd2);
    flush        = 1'b1;
    bus.in_data  = 32'h00C0FFEE;
    bus.in_tag   = 4'h9;
    tick();
    flush = 1'b0;
    chk("flush_in_ready", 64'(last_in_ready), 64'd0);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("post_flush_lat1", 64'(bus.out_valid), 64'd0);
    tick();
    chk("post_flush_valid", 64'(bus.out_valid), 64'd1);
    chk("post_flush_data", 64'(bus.out_data), 64'(ref_sub(32'h00C0FFEE, 1'b0)));
    tick();
    chk("post_flush_alone", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset mid-stream.
    for (int c = 0; c < 3; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h01010101 * (c + 1);
      bus.in_tag   = 4'hF;
      tick();
    end
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("async_rst_data", 64'(bus.out_data), 64'd0);
    chk("async_rst_tag", 64'(bus.out_tag), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_inv   = 1'b1;
    bus.in_data  = $urandom;
    bus.in_tag   = 4'h3;
    tick();
    bus.in_valid = 1'b0;
    drain("post_rst_drain");

`ifdef AES_SBOX_PIPE_CHECK_EN
    // Clean sweep leaves the sticky flag clear.
    sweep();
    drain("chk_sweep_drain");
    chk("chk_sticky_clean", 64'(err_sticky), 64'd0);

    // Stuck lane 0 on the output beat.
    bus.in_valid = 1'b1;
    bus.in_inv   = 1'b0;
    bus.in_data  = 32'h00000001;
    bus.in_tag   = 4'h3;
    tick();
    bus.in_valid = 1'b0;
    tick();
    fault_val = ref_sub(32'h00000001, 1'b0) & ~32'h000000FF;
    force dut.out_bytes = fault_val;
    #1;
    chk("chk_err_beat", 64'(err_beat), 64'd1);
    skip_data = 1'b1;
    tick();
    skip_data = 1'b0;
    release dut.out_bytes;
    chk("chk_sticky_set", 64'(err_sticky), 64'd1);
    tick();
    tick();
    chk("chk_sticky_hold", 64'(err_sticky), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("chk_sticky_rst", 64'(err_sticky), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
